// File: rtl/debug_reg_probe.sv
// debug_reg_probe: turns the register-select PIO value into read requests on
// the core's debug register-file port, captures the returned value with a
// sequence number, and exposes DATA/STATUS/CTRL/TMO on a zero-wait-state
// Avalon-MM slave. The current select is re-read every REFRESH_CYCLES idle
// cycles so the host sees live values.
//
// Optional feature macro: DBG_PROBE_TIMEOUT_EN
//   defined   - a request that sees no dbg_ack within TIMEOUT_CYCLES cycles is
//               abandoned; err is set and the TMO counter increments.
//   undefined - a request waits forever; err and TMO read as constant zero.
module debug_reg_probe #(
    parameter int unsigned REFRESH_CYCLES = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  sel_in,
    output logic        dbg_req,
    output logic [4:0]  dbg_addr,
    input  logic        dbg_ack,
    input  logic [31:0] dbg_data,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Refresh counter runs 0 .. REFRESH_CYCLES-1; the last value is the expiry.
    localparam int unsigned REF_LAST = (REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1;
    localparam int          REF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_TMO    = 2'd3;

    state_t             state_q;
    logic               dbg_req_q;
    logic [4:0]         dbg_addr_q;
    logic [31:0]        data_q;
    logic [4:0]         cap_sel_q;
    logic               valid_q;
    logic [7:0]         seq_q;
    logic [7:0]         seq_d;
    logic               freeze_q;
    logic [REF_W-1:0]   refresh_cnt_q;

    logic               ctrl_wr;
    logic               capture_wr;
    logic               sel_change;
    logic               refresh_hit;
    logic               auto_trig;
    logic               trigger;

    logic               err_bit;
    logic [7:0]         tmo_val;

    // Writes to the RO addresses are simply not decoded; only CTRL is writable.
    assign ctrl_wr     = chipselect && !write_n && (address == ADDR_CTRL);
    assign capture_wr  = ctrl_wr && writedata[1];
    assign sel_change  = (sel_in != cap_sel_q);
    assign refresh_hit = (REFRESH_CYCLES != 0) && (refresh_cnt_q == REF_W'(REF_LAST));
    // Freeze masks the automatic triggers but never a host capture request.
    assign auto_trig   = !freeze_q && (sel_change || refresh_hit);
    // A capture written while a request is outstanding is dropped here.
    assign trigger     = (state_q == ST_IDLE) && (capture_wr || auto_trig);
    assign seq_d       = seq_q + 8'd1;

`ifdef DBG_PROBE_TIMEOUT_EN
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam int          TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic            err_q;
    logic [7:0]      tmo_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            to_hit;

    assign to_hit  = (to_cnt_q == TO_W'(TO_LAST));
    assign err_bit = err_q;
    assign tmo_val = tmo_q;
`else
    // No timeout hardware: err and TMO are tied off.
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign err_bit = 1'b0;
    assign tmo_val = 8'd0;
`endif

    // Main FSM: trigger decode in IDLE, request/capture handshake in REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            dbg_req_q     <= 1'b0;
            dbg_addr_q    <= 5'd0;
            data_q        <= 32'd0;
            cap_sel_q     <= 5'd0;
            valid_q       <= 1'b0;
            seq_q         <= 8'd0;
            freeze_q      <= 1'b0;
            refresh_cnt_q <= '0;
`ifdef DBG_PROBE_TIMEOUT_EN
            err_q         <= 1'b0;
            tmo_q         <= 8'd0;
            to_cnt_q      <= '0;
`endif
        end else begin
            if (ctrl_wr) begin
                freeze_q <= writedata[0];
            end

            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        refresh_cnt_q <= '0;
                        dbg_addr_q    <= sel_in;
                        if (sel_in == 5'd0) begin
                            // x0 is hardwired to zero: capture without asking the core.
                            data_q    <= 32'd0;
                            cap_sel_q <= 5'd0;
                            valid_q   <= 1'b1;
                            seq_q     <= seq_d;
                        end else begin
                            state_q   <= ST_REQ;
                            dbg_req_q <= 1'b1;
`ifdef DBG_PROBE_TIMEOUT_EN
                            to_cnt_q  <= '0;
`endif
                        end
                    end else if (refresh_hit) begin
                        // Expiry while frozen is swallowed; restart the interval.
                        refresh_cnt_q <= '0;
                    end else begin
                        refresh_cnt_q <= refresh_cnt_q + 1'b1;
                    end
                end

                ST_REQ: begin
                    // dbg_addr_q is held here even if sel_in moves; the newer
                    // select retriggers from IDLE because it differs from cap_sel.
                    if (dbg_ack) begin
                        data_q    <= dbg_data;
                        cap_sel_q <= dbg_addr_q;
                        valid_q   <= 1'b1;
                        seq_q     <= seq_d;
                        state_q   <= ST_IDLE;
                        dbg_req_q <= 1'b0;
`ifdef DBG_PROBE_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                    end
`ifdef DBG_PROBE_TIMEOUT_EN
                    else if (to_hit) begin
                        // Abandon the request; captured data and seq stay as they were.
                        state_q   <= ST_IDLE;
                        dbg_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        if (tmo_q != 8'hFF) begin
                            tmo_q <= tmo_q + 8'd1;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    assign dbg_req  = dbg_req_q;
    assign dbg_addr = dbg_addr_q;

    // Zero-wait-state read mux, purely from the word address.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:   readdata = data_q;
            ADDR_STATUS: readdata = {8'd0, seq_q, 5'd0, err_bit, (state_q == ST_REQ),
                                     valid_q, 3'd0, cap_sel_q};
            ADDR_CTRL:   readdata = {31'd0, freeze_q};
            ADDR_TMO:    readdata = {24'd0, tmo_val};
            default:     readdata = 32'd0;
        endcase
    end

    // Only CTRL bits [1:0] carry meaning; the rest of the write bus is ignored.
    logic unused_writedata;
    assign unused_writedata = ^writedata[31:2];

endmodule

// File: tb/tb_debug_reg_probe.sv
// Directed bench for debug_reg_probe: table of select/ack vectors plus
// hand-written sequences for retrigger-in-REQ, freeze/capture, refresh,
// timeout (when DBG_PROBE_TIMEOUT_EN is defined), seq wrap and reset in REQ.
module tb_debug_reg_probe;

    localparam int REFRESH = 16;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  sel_in;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_data;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    debug_reg_probe #(
        .REFRESH_CYCLES (REFRESH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel_in     (sel_in),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_ack    (dbg_ack),
        .dbg_data   (dbg_data),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  sel;
        int          delay;
        logic [31:0] ack_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [7:0]  exp_seq;
    logic [4:0]  exp_cap;
    logic        exp_err;
    logic [7:0]  exp_tmo;
    logic [31:0] exp_dat;
    logic [31:0] rd_val;
    int          req_cnt;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    function automatic logic [31:0] st(input logic [4:0] c, input logic v, input logic b,
                                       input logic e, input logic [7:0] s);
        return {8'd0, s, 5'd0, e, b, v, 3'd0, c};
    endfunction

    task automatic check_regs(input string tag, input logic [31:0] d, input logic [31:0] s);
        logic [31:0] r;
        rd(2'd0, r);
        check({tag, " DATA"}, r, d);
        rd(2'd1, r);
        check({tag, " STATUS"}, r, s);
    endtask

    // Count request cycles over n ticks.
    task automatic count_req(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (dbg_req) cnt++;
        end
    endtask

    initial begin
        vecs[0] = '{sel: 5'd7,  delay: 3, ack_data: 32'hDEADBEEF, exp_data: 32'hDEADBEEF};
        vecs[1] = '{sel: 5'd31, delay: 1, ack_data: 32'h12345678, exp_data: 32'h12345678};
        vecs[2] = '{sel: 5'd0,  delay: 0, ack_data: 32'hFFFFFFFF, exp_data: 32'h00000000};
        vecs[3] = '{sel: 5'd1,  delay: 2, ack_data: 32'hA5A5A5A5, exp_data: 32'hA5A5A5A5};
        vecs[4] = '{sel: 5'd0,  delay: 0, ack_data: 32'h11111111, exp_data: 32'h00000000};
        vecs[5] = '{sel: 5'd30, delay: 4, ack_data: 32'h0BADF00D, exp_data: 32'h0BADF00D};

        reset = 1'b1; sel_in = 5'd0; dbg_ack = 1'b0; dbg_data = 32'd0;
        address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        exp_seq = 8'd0; exp_cap = 5'd0; exp_err = 1'b0; exp_tmo = 8'd0; exp_dat = 32'd0;

        // ---- reset state
        tick(); tick(); tick();
        check("rst dbg_req", {31'd0, dbg_req}, 32'd0);
        check("rst dbg_addr", {27'd0, dbg_addr}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], rd_val);
            check($sformatf("rst reg%0d", a), rd_val, 32'd0);
        end
        reset = 1'b0;

        // ---- refresh of x0 after reset: no request, DATA=0, seq=1
        count_req(15, req_cnt);
        rd(2'd1, rd_val);
        check("pre-refresh STATUS", rd_val, st(5'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        begin
            int more;
            count_req(2, more);
            req_cnt += more;
        end
        check("x0 refresh req cycles", req_cnt, 32'd0);
        exp_seq = 8'd1;
        check_regs("x0 refresh", 32'd0, st(5'd0, 1'b1, 1'b0, 1'b0, exp_seq));

        // ---- table-driven captures
        foreach (vecs[k]) begin
            sel_in = vecs[k].sel;
            tick();
            if (vecs[k].sel == 5'd0) begin
                check($sformatf("v%0d no req", k), {31'd0, dbg_req}, 32'd0);
                check($sformatf("v%0d dbg_addr", k), {27'd0, dbg_addr}, 32'd0);
            end else begin
                for (int i = 0; i < vecs[k].delay; i++) begin
                    check($sformatf("v%0d req c%0d", k, i), {31'd0, dbg_req}, 32'd1);
                    check($sformatf("v%0d addr c%0d", k, i), {27'd0, dbg_addr}, {27'd0, vecs[k].sel});
                    if (i == vecs[k].delay - 1) begin
                        dbg_ack  = 1'b1;
                        dbg_data = vecs[k].ack_data;
                    end
                    tick();
                end
                dbg_ack = 1'b0;
                check($sformatf("v%0d req drop", k), {31'd0, dbg_req}, 32'd0);
            end
            exp_seq = exp_seq + 8'd1;
            exp_cap = vecs[k].sel;
            exp_dat = vecs[k].exp_data;
            check_regs($sformatf("v%0d", k), exp_dat, st(exp_cap, 1'b1, 1'b0, 1'b0, exp_seq));
        end

        // ---- select changes 7 -> 9 while in REQ
        sel_in = 5'd7;
        tick();
        check("chg req", {31'd0, dbg_req}, 32'd1);
        sel_in = 5'd9;
        tick();
        check("chg addr held", {27'd0, dbg_addr}, 32'd7);
        dbg_ack = 1'b1; dbg_data = 32'h77777777;
        tick();
        dbg_ack = 1'b0;
        check("chg req drop", {31'd0, dbg_req}, 32'd0);
        exp_seq = exp_seq + 8'd1;
        check_regs("chg first", 32'h77777777, st(5'd7, 1'b1, 1'b0, 1'b0, exp_seq));
        tick();
        check("chg rereq", {31'd0, dbg_req}, 32'd1);
        check("chg rereq addr", {27'd0, dbg_addr}, 32'd9);
        dbg_ack = 1'b1; dbg_data = 32'h99999999;
        tick();
        dbg_ack = 1'b0;
        exp_seq = exp_seq + 8'd1;
        check_regs("chg second", 32'h99999999, st(5'd9, 1'b1, 1'b0, 1'b0, exp_seq));

        // ---- freeze blocks changes and refresh; capture overrides
        wr(2'd2, 32'd1);
        rd(2'd2, rd_val);
        check("freeze CTRL", rd_val, 32'd1);
        sel_in = 5'd12;
        count_req(20, req_cnt);
        check("frozen req cycles", req_cnt, 32'd0);
        check_regs("frozen", 32'h99999999, st(5'd9, 1'b1, 1'b0, 1'b0, exp_seq));
        wr(2'd2, 32'd2);
        check("capture req", {31'd0, dbg_req}, 32'd1);
        check("capture addr", {27'd0, dbg_addr}, 32'd12);
        rd(2'd2, rd_val);
        check("capture CTRL", rd_val, 32'd0);
        rd(2'd1, rd_val);
        check("capture busy", rd_val, st(5'd9, 1'b1, 1'b1, 1'b0, exp_seq));
        dbg_ack = 1'b1; dbg_data = 32'hC0C0C0C0;
        tick();
        dbg_ack = 1'b0;
        exp_seq = exp_seq + 8'd1;
        check_regs("capture", 32'hC0C0C0C0, st(5'd12, 1'b1, 1'b0, 1'b0, exp_seq));
        count_req(3, req_cnt);
        check("capture single req", req_cnt, 32'd0);

        // ---- capture written while busy is dropped
        sel_in = 5'd5;
        tick();
        check("busy req", {31'd0, dbg_req}, 32'd1);
        wr(2'd2, 32'd2);
        check("busy still req", {31'd0, dbg_req}, 32'd1);
        dbg_ack = 1'b1; dbg_data = 32'h55550001;
        tick();
        dbg_ack = 1'b0;
        exp_seq = exp_seq + 8'd1;
        check_regs("busy cap", 32'h55550001, st(5'd5, 1'b1, 1'b0, 1'b0, exp_seq));
        count_req(3, req_cnt);
        check("busy cap dropped", req_cnt, 32'd0);

        // ---- auto-refresh re-reads the current non-zero select
        for (int i = 0; i < 20 && !dbg_req; i++) tick();
        check("refresh req", {31'd0, dbg_req}, 32'd1);
        check("refresh addr", {27'd0, dbg_addr}, 32'd5);
        dbg_ack = 1'b1; dbg_data = 32'h0F0F0F0F;
        tick();
        dbg_ack = 1'b0;
        exp_seq = exp_seq + 8'd1;
        check_regs("refresh", 32'h0F0F0F0F, st(5'd5, 1'b1, 1'b0, 1'b0, exp_seq));

`ifdef DBG_PROBE_TIMEOUT_EN
        // ---- timeout: no ack for TIMEOUT cycles
        sel_in = 5'd3;
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            check($sformatf("tmo req c%0d", i), {31'd0, dbg_req}, 32'd1);
            tick();
        end
        check("tmo req drop", {31'd0, dbg_req}, 32'd0);
        check_regs("tmo", 32'h0F0F0F0F, st(5'd5, 1'b1, 1'b0, 1'b1, exp_seq));
        rd(2'd3, rd_val);
        check("tmo count", rd_val, 32'd1);
        tick();
        check("tmo retrigger", {31'd0, dbg_req}, 32'd1);
        check("tmo retrigger addr", {27'd0, dbg_addr}, 32'd3);
        dbg_ack = 1'b1; dbg_data = 32'h33333333;
        tick();
        dbg_ack = 1'b0;
`else
        sel_in = 5'd3;
        tick();
        check("sel3 req", {31'd0, dbg_req}, 32'd1);
        dbg_ack = 1'b1; dbg_data = 32'h33333333;
        tick();
        dbg_ack = 1'b0;
        rd(2'd3, rd_val);
        check("TMO tied zero", rd_val, 32'd0);
`endif
        exp_seq = exp_seq + 8'd1;
        check_regs("sel3", 32'h33333333, st(5'd3, 1'b1, 1'b0, 1'b0, exp_seq));

        // ---- seq wrap via x0 captures
        sel_in = 5'd0;
        tick();
        exp_seq = exp_seq + 8'd1;
        while (exp_seq != 8'd255) begin
            wr(2'd2, 32'd2);
            exp_seq = exp_seq + 8'd1;
        end
        rd(2'd1, rd_val);
        check("seq 255", rd_val, st(5'd0, 1'b1, 1'b0, 1'b0, 8'd255));
        wr(2'd2, 32'd2);
        check_regs("seq wrap", 32'd0, st(5'd0, 1'b1, 1'b0, 1'b0, 8'd0));

        // ---- reset asserted in REQ, with a coincident ack
        sel_in = 5'd20;
        tick();
        check("pre-rst req", {31'd0, dbg_req}, 32'd1);
        wr(2'd2, 32'd1);
        rd(2'd2, rd_val);
        check("pre-rst freeze", rd_val, 32'd1);
        reset = 1'b1; dbg_ack = 1'b1; dbg_data = 32'hBAD0BAD0;
        tick();
        dbg_ack = 1'b0;
        check("rst2 dbg_req", {31'd0, dbg_req}, 32'd0);
        check("rst2 dbg_addr", {27'd0, dbg_addr}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], rd_val);
            check($sformatf("rst2 reg%0d", a), rd_val, 32'd0);
        end
        sel_in = 5'd0;
        tick();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
